demux1n_striper: RTL and testbench

//  Parametrised 1-to-N byte demux/striper. Successor to the fixed 1:2 demux in the PCIe PHY path.

---
 rtl/demux_pkg.sv | 31 +++
 rtl/demux_frame_reg.sv | 48 ++++
 rtl/demux1n_striper.sv | 138 +++++++++++++
 tb/tb_demux1n_striper.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared widths, lane-count clamp and lane-mask helpers for the byte striper
//
// Purpose: constants and small pure functions used by demux1n_striper and
// demux_frame_reg. Widths here are for the default 4-lane build; the top
// recomputes its own from its NLANES parameter.
// Ports: none (package).
package demux_pkg;

  localparam int DEF_NLANES = 4;
  localparam int DEF_LW     = $clog2(DEF_NLANES + 1);  // width of a lane count 0..NLANES
  localparam int DEF_IW     = $clog2(DEF_NLANES);      // width of a lane index 0..NLANES-1
  localparam int MAX_LANES  = 32;                      // widest mask lane_mask can build

  localparam logic [7:0] DEF_PAD_BYTE = 8'hBC;

  // Requested lane count; 0 or anything above the physical count means "all lanes".
  function automatic int clamp_lanes(int n, int nlanes);
    return ((n < 1) || (n > nlanes)) ? nlanes : n;
  endfunction

  // Ones in bits 0..n-1. Callers truncate to their own lane count.
  function automatic logic [MAX_LANES-1:0] lane_mask(int n);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/demux_frame_reg.sv
// rtl/demux_frame_reg.sv - output frame holding register with load/drain handshake
//
// Purpose: holds the frame presented to the lane encoders until taken.
// Ports:
//   clk4f      in   clock, posedge
//   reset      in   synchronous active-low reset
//   load       in   capture load_data/load_valid this cycle (caller guarantees slot free)
//   load_data  in   NLANES*W frame contents
//   load_valid in   NLANES per-lane valid for the frame
//   out_ready  in   downstream takes the frame when validout!=0
//   out        out  presented frame, lane k at out[k*W +: W]
//   validout   out  per-lane valid of the presented frame
//   out_full   out  a frame is presented (|validout)
module demux_frame_reg
  import demux_pkg::*;
#(
  parameter int W      = 8,
  parameter int NLANES = DEF_NLANES
) (
  input  logic                clk4f,
  input  logic                reset,
  input  logic                load,
  input  logic [NLANES*W-1:0] load_data,
  input  logic [NLANES-1:0]   load_valid,
  input  logic                out_ready,
  output logic [NLANES*W-1:0] out,
  output logic [NLANES-1:0]   validout,
  output logic                out_full
);

  assign out_full = |validout;

  // A load takes priority over a drain so a frame completing in the same cycle
  // the previous one is taken replaces it with no empty cycle in between.
  always_ff @(posedge clk4f) begin
    if (!reset) begin
      out      <= '0;
      validout <= '0;
    end else if (load) begin
      out      <= load_data;
      validout <= load_valid;
    end else if (out_full && out_ready) begin
      out      <= '0;
      validout <= '0;
    end
  end

endmodule

// File: rtl/demux1n_striper.sv
// rtl/demux1n_striper.sv - 1-to-N round-robin byte striper with runtime lane count
//
// Purpose: stripes accepted bytes across cfg_lanes lanes (lane 0 first) and
// presents each completed lane set as one parallel frame.
// Optional feature: define PAD_FLUSH_EN to flush a partial frame, padded with
// PAD_BYTE, after FLUSH_TIMEOUT idle cycles. Without it partial frames wait.
// Ports:
//   clk4f        in   clock, posedge
//   reset        in   synchronous active-low reset
//   in           in   input byte
//   valid        in   input byte valid
//   in_ready     out  byte accepted when valid & in_ready
//   active_lanes in   lanes to use, 1..NLANES (0 or too large means NLANES)
//   out          out  frame, lane k at out[k*W +: W]
//   validout     out  per-lane valid
//   out_ready    in   downstream takes the frame when validout!=0
module demux1n_striper
  import demux_pkg::*;
#(
  parameter int           W             = 8,
  parameter int           NLANES        = DEF_NLANES,
  parameter int           FLUSH_TIMEOUT = 8,
  parameter logic [W-1:0] PAD_BYTE      = W'(DEF_PAD_BYTE)
) (
  input  logic                          clk4f,
  input  logic                          reset,
  input  logic [W-1:0]                  in,
  input  logic                          valid,
  output logic                          in_ready,
  input  logic [$clog2(NLANES+1)-1:0]   active_lanes,
  output logic [NLANES*W-1:0]           out,
  output logic [NLANES-1:0]             validout,
  input  logic                          out_ready
);

  localparam int LW = $clog2(NLANES + 1);
  localparam int IW = $clog2(NLANES);
  localparam int CW = $clog2(FLUSH_TIMEOUT + 1);

`ifdef PAD_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic [IW-1:0]       ptr;
  logic [LW-1:0]       cfg_lanes;
  logic [NLANES*W-1:0] stage;
  logic [CW-1:0]       idle_cnt;

  logic                out_full;
  logic                slot_free;
  logic                accept;
  logic                frame_done;
  logic                flush_fire;
  logic                load;
  logic [LW-1:0]       req_lanes;
  logic [LW-1:0]       eff_lanes;
  logic [NLANES*W-1:0] load_data;
  logic [NLANES-1:0]   load_valid;

  assign slot_free = ~out_full | out_ready;
  assign in_ready  = reset & slot_free;
  assign accept    = valid & in_ready;

  // Between frames the live request applies, so the first byte of a frame
  // already uses the newly requested lane count; mid-frame the latched one does.
  assign req_lanes = LW'(clamp_lanes(int'(active_lanes), NLANES));
  assign eff_lanes = (ptr == '0) ? req_lanes : cfg_lanes;

  assign frame_done = accept && (int'(ptr) == int'(eff_lanes) - 1);

  // A flush never coincides with an accept: an arriving byte cancels it.
  assign flush_fire = FLUSH_EN && reset && (ptr != '0) && !accept &&
                      (int'(idle_cnt) == FLUSH_TIMEOUT) && slot_free;

  assign load = frame_done | flush_fire;

  // Frame contents: the byte arriving this cycle is merged at ptr so it appears
  // in the frame one cycle after acceptance. On flush, filled lanes keep their
  // bytes and the rest of the active set carries PAD_BYTE. Lanes beyond the
  // active set are always 0.
  always_comb begin
    load_data = '0;
    for (int k = 0; k < NLANES; k++) begin
      if (k < int'(eff_lanes)) begin
        if (flush_fire) begin
          load_data[k*W +: W] = (k < int'(ptr)) ? stage[k*W +: W] : PAD_BYTE;
        end else begin
          load_data[k*W +: W] = (k == int'(ptr)) ? in : stage[k*W +: W];
        end
      end
    end
    load_valid = flush_fire ? NLANES'(lane_mask(int'(ptr)))
                            : NLANES'(lane_mask(int'(eff_lanes)));
  end

  always_ff @(posedge clk4f) begin
    if (!reset) begin
      ptr       <= '0;
      cfg_lanes <= LW'(NLANES);
      stage     <= '0;
      idle_cnt  <= '0;
    end else begin
      if (ptr == '0) cfg_lanes <= req_lanes;

      if (accept) begin
        stage[ptr*W +: W] <= in;
        ptr               <= frame_done ? '0 : ptr + 1'b1;
      end else if (flush_fire) begin
        ptr <= '0;
      end

      // Counts idle cycles while a partial frame is held; saturates at the timeout.
      if (accept || flush_fire || (ptr == '0)) begin
        idle_cnt <= '0;
      end else if (int'(idle_cnt) < FLUSH_TIMEOUT) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  demux_frame_reg #(
    .W      (W),
    .NLANES (NLANES)
  ) u_frame_reg (
    .clk4f      (clk4f),
    .reset      (reset),
    .load       (load),
    .load_data  (load_data),
    .load_valid (load_valid),
    .out_ready  (out_ready),
    .out        (out),
    .validout   (validout),
    .out_full   (out_full)
  );

endmodule

// File: tb/tb_demux1n_striper.sv
// tb/tb_demux1n_striper.sv - self-checking bench for demux1n_striper
module tb_demux1n_striper;

  localparam int FT = 8;

  logic        clk4f = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in = 8'h00;
  logic        valid = 1'b0;
  logic        in_ready;
  logic [2:0]  active_lanes = 3'd4;
  logic [31:0] out;
  logic [3:0]  validout;
  logic        out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk4f = ~clk4f;

  demux1n_striper #(
    .W             (8),
    .NLANES        (4),
    .FLUSH_TIMEOUT (FT),
    .PAD_BYTE      (8'hBC)
  ) dut (
    .clk4f        (clk4f),
    .reset        (reset),
    .in           (in),
    .valid        (valid),
    .in_ready     (in_ready),
    .active_lanes (active_lanes),
    .out          (out),
    .validout     (validout),
    .out_ready    (out_ready)
  );

  // Reference: a queue of bytes collected for the current frame and the frame
  // that should currently be on the outputs.
  logic [7:0]  mq[$];
  int          m_lanes = 4;
  logic [31:0] m_out = '0;
  logic [3:0]  m_vld = '0;
  int          m_idle = 0;

  function automatic int clampl(int a);
    return (a == 0 || a > 4) ? 4 : a;
  endfunction

  always @(posedge clk4f) begin : model
    logic        acc;
    logic        ld;
    logic [31:0] nout;
    logic [3:0]  nvld;
    ld = 1'b0;
    nout = '0;
    nvld = '0;
    if (!reset) begin
      mq.delete();
      m_out = '0;
      m_vld = '0;
      m_idle = 0;
    end else begin
      acc = valid && (m_vld == 0 || out_ready);
      if (acc) begin
        if (mq.size() == 0) m_lanes = clampl(int'(active_lanes));
        mq.push_back(in);
        m_idle = 0;
        if (mq.size() == m_lanes) begin
          for (int i = 0; i < m_lanes; i++) nout[i*8 +: 8] = mq[i];
          nvld = 4'((1 << m_lanes) - 1);
          ld = 1'b1;
          mq.delete();
        end
      end else if (mq.size() != 0) begin
`ifdef PAD_FLUSH_EN
        if (m_idle == FT && (m_vld == 0 || out_ready)) begin
          for (int i = 0; i < m_lanes; i++) nout[i*8 +: 8] = (i < mq.size()) ? mq[i] : 8'hBC;
          nvld = 4'((1 << mq.size()) - 1);
          ld = 1'b1;
          mq.delete();
          m_idle = 0;
        end else if (m_idle < FT) begin
          m_idle++;
        end
`endif
      end
      if (ld) begin
        m_out = nout;
        m_vld = nvld;
      end else if (m_vld != 0 && out_ready) begin
        m_out = '0;
        m_vld = '0;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, then compare against the model.
  task automatic step(logic v, logic [7:0] d, logic rdy, logic [2:0] al, logic rst);
    @(negedge clk4f);
    valid = v;
    in = d;
    out_ready = rdy;
    active_lanes = al;
    reset = rst;
    #1;
    chk("out", out, m_out);
    chk("validout", {28'd0, validout}, {28'd0, m_vld});
    chk("in_ready", {31'd0, in_ready}, {31'd0, (reset && (m_vld == 0 || out_ready))});
  endtask

  int found;

  initial begin
    // Reset held with valid asserted
    repeat (4) step(1'b1, 8'hFF, 1'b1, 3'd4, 1'b0);
    chk("rst_out", out, 32'h0);
    chk("rst_validout", {28'd0, validout}, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'h0);
    step(1'b1, 8'h5A, 1'b1, 3'd1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 3'd4, 1'b1);
    chk("first_lane0", out, 32'h0000005A);
    chk("first_lane0_vo", {28'd0, validout}, 32'h1);

    // Four-lane stripe
    step(1'b1, 8'hFF, 1'b1, 3'd4, 1'b1);
    step(1'b1, 8'hDD, 1'b1, 3'd4, 1'b1);
    step(1'b1, 8'hEE, 1'b1, 3'd4, 1'b1);
    step(1'b1, 8'hCC, 1'b1, 3'd4, 1'b1);
    step(1'b0, 8'h00, 1'b1, 3'd4, 1'b1);
    chk("stripe4", out, 32'hCCEEDDFF);
    chk("stripe4_vo", {28'd0, validout}, 32'hF);

    // Two-lane mode
    step(1'b1, 8'hBB, 1'b1, 3'd2, 1'b1);
    step(1'b1, 8'h99, 1'b1, 3'd2, 1'b1);
    step(1'b1, 8'hAA, 1'b1, 3'd2, 1'b1);
    chk("mode2_a", out, 32'h000099BB);
    chk("mode2_a_vo", {28'd0, validout}, 32'h3);
    step(1'b1, 8'h88, 1'b1, 3'd2, 1'b1);
    step(1'b0, 8'h00, 1'b1, 3'd2, 1'b1);
    chk("mode2_b", out, 32'h000088AA);

    // Backpressure, then 77 frame after release
    step(1'b1, 8'h11, 1'b0, 3'd4, 1'b1);
    step(1'b1, 8'h22, 1'b0, 3'd4, 1'b1);
    step(1'b1, 8'h33, 1'b0, 3'd4, 1'b1);
    step(1'b1, 8'h44, 1'b0, 3'd4, 1'b1);
    repeat (3) begin
      step(1'b1, 8'h77, 1'b0, 3'd4, 1'b1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'h0);
      chk("bp_hold", out, 32'h44332211);
    end
    repeat (4) step(1'b1, 8'h77, 1'b1, 3'd4, 1'b1);
    step(1'b0, 8'h00, 1'b0, 3'd4, 1'b1);
    chk("bp_release", out, 32'h77777777);
    chk("bp_release_vo", {28'd0, validout}, 32'hF);

    // Single lane: a new frame every cycle while the previous one is taken
    step(1'b1, 8'hA1, 1'b1, 3'd1, 1'b1);
    step(1'b1, 8'hA2, 1'b1, 3'd1, 1'b1);
    chk("b2b_1", out, 32'h000000A1);
    step(1'b1, 8'hA3, 1'b1, 3'd1, 1'b1);
    chk("b2b_2", out, 32'h000000A2);
    step(1'b0, 8'h00, 1'b1, 3'd4, 1'b1);

    // Mid-frame reset discards the partial frame
    step(1'b1, 8'hE1, 1'b1, 3'd4, 1'b1);
    step(1'b1, 8'hE2, 1'b1, 3'd4, 1'b1);
    step(1'b0, 8'h00, 1'b1, 3'd4, 1'b0);
    step(1'b1, 8'h01, 1'b1, 3'd4, 1'b1);
    step(1'b1, 8'h02, 1'b1, 3'd4, 1'b1);
    step(1'b1, 8'h03, 1'b1, 3'd4, 1'b1);
    step(1'b1, 8'h04, 1'b1, 3'd4, 1'b1);
    step(1'b0, 8'h00, 1'b0, 3'd4, 1'b1);
    chk("post_reset_frame", out, 32'h04030201);
    step(1'b0, 8'h00, 1'b1, 3'd4, 1'b1);

    // Partial frame then idle
    step(1'b1, 8'hAA, 1'b1, 3'd4, 1'b1);
    step(1'b1, 8'hBB, 1'b1, 3'd4, 1'b1);
    step(1'b1, 8'hCC, 1'b1, 3'd4, 1'b1);
    found = 0;
    repeat (20) begin
      step(1'b0, 8'h00, 1'b1, 3'd4, 1'b1);
`ifdef PAD_FLUSH_EN
      if (validout != 0 && found == 0) begin
        found = 1;
        chk("flush_out", out, 32'hBCCCBBAA);
        chk("flush_vo", {28'd0, validout}, 32'h7);
      end
`else
      if (validout != 0) found = 1;
`endif
    end
`ifdef PAD_FLUSH_EN
    chk("flush_seen", found, 1);
`else
    chk("no_flush", found, 0);
`endif
    step(1'b0, 8'h00, 1'b1, 3'd4, 1'b0);

    // Random traffic: busy phase, then a sparse phase with long idle gaps
    repeat (3000) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) != 0,
           3'($urandom % 8), ($urandom % 200) != 0);
    end
    repeat (2000) begin
      step(($urandom % 12) == 0, 8'($urandom), ($urandom % 3) != 0,
           3'($urandom % 8), ($urandom % 300) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
